// File: rtl/cnn_pkg.sv
// Shared definitions for the streaming CNN front end: default pixel width,
// flush FSM states and small elaboration-time helpers.
package cnn_pkg;

    localparam int CNN_DATA_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } lb_state_t;

    // Counter width for n states; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of output rows once vertical padding is applied.
    function automatic int out_h(input int img_h, input int k, input int pad);
        return img_h + 2 * pad - k + 1;
    endfunction

    // Image row feeding a given lane when the newest row is 'row'.
    function automatic int lane_src_row(input int row, input int k, input int lane);
        return row - (k - 1) + lane;
    endfunction

endpackage

// File: rtl/line_mem.sv
// One image row of storage. The read is combinational so the old value at
// 'addr' is seen in the same cycle that a new value is written there.
module line_mem
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int DEPTH  = 28,
    parameter int A_W    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_W-1:0]    addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write the shifted-in pixel after the old one has been read out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer_kxk.sv
// K-row vertical line buffer. Each accepted pixel yields one K-tall column
// (lane 0 oldest row, lane K-1 newest). Top padding comes from masking lanes
// that point above the image; bottom padding is produced by a FLUSH phase
// that walks virtual rows below the image with input stalled.
module line_buffer_kxk
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int PAD    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [K*DATA_W-1:0]                    out_col,
    output logic                                   out_valid,
    output logic [cnt_w(IMG_W)-1:0]                out_x,
    output logic [cnt_w(out_h(IMG_H, K, PAD))-1:0] out_y,
    output logic                                   frame_done
);

    localparam int OUT_H = out_h(IMG_H, K, PAD);
    localparam int X_W   = cnt_w(IMG_W);
    localparam int Y_W   = cnt_w(OUT_H);
    localparam int R_W   = cnt_w(IMG_H + PAD);

    localparam logic [X_W-1:0] X_LAST        = X_W'(IMG_W - 1);
    localparam logic [R_W-1:0] R_IMG_LAST    = R_W'(IMG_H - 1);
    localparam logic [R_W-1:0] R_FLUSH_FIRST = R_W'(IMG_H);
    localparam logic [R_W-1:0] R_FINAL       = R_W'(IMG_H + PAD - 1);
    // First row (real or virtual) whose column lands inside the padded output.
    localparam int FIRST_OUT_ROW = K - 1 - PAD;

    lb_state_t           state;
    logic [X_W-1:0]      x;
    logic [R_W-1:0]      r;
    logic                accept;
    logic                step;
    logic                row_emits;
    logic                last_col;
    logic [DATA_W-1:0]   cur_pix;
    logic [DATA_W-1:0]   rd [K-1];
    logic [K*DATA_W-1:0] raw_col;
    logic [K*DATA_W-1:0] col_next;

    assign accept    = in_valid && in_ready;
    // FLUSH advances one virtual column per cycle regardless of upstream.
    assign step      = (state == FLUSH) || accept;
    assign cur_pix   = (state == RUN) ? in_data : '0;
    assign row_emits = int'(r) >= FIRST_OUT_ROW;
    assign last_col  = (x == X_LAST);

    // Delay chain: memory i holds the row i+1 above the newest one.
    for (genvar i = 0; i < K - 1; i++) begin : g_mem
        logic [DATA_W-1:0] wdata;
        if (i == 0) begin : g_head
            assign wdata = cur_pix;
        end else begin : g_chain
            assign wdata = rd[i-1];
        end
        line_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W),
            .A_W    (X_W)
        ) u_mem (
            .clk   (clk),
            .we    (step),
            .addr  (x),
            .wdata (wdata),
            .rdata (rd[i])
        );
    end

    for (genvar j = 0; j < K; j++) begin : g_lane
        if (j == K - 1) begin : g_newest
            assign raw_col[j*DATA_W +: DATA_W] = cur_pix;
        end else begin : g_stored
            assign raw_col[j*DATA_W +: DATA_W] = rd[K-2-j];
        end
    end

    // Zero every lane whose source row lies outside the image; this also
    // hides stale rows left over from the previous frame.
    always_comb begin
        col_next = '0;
        for (int j = 0; j < K; j++) begin
            if (lane_src_row(int'(r), K, j) >= 0 && lane_src_row(int'(r), K, j) < IMG_H) begin
                col_next[j*DATA_W +: DATA_W] = raw_col[j*DATA_W +: DATA_W];
            end
        end
    end

    // Column/row counters and the RUN/FLUSH sequencing with registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            in_ready <= 1'b1;
            x        <= '0;
            r        <= '0;
        end else if (step) begin
            if (!last_col) begin
                x <= x + 1'b1;
            end else begin
                x <= '0;
                if (state == RUN) begin
                    if (r == R_IMG_LAST) begin
                        if (PAD > 0) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            r        <= R_FLUSH_FIRST;
                        end else begin
                            r <= '0;
                        end
                    end else begin
                        r <= r + 1'b1;
                    end
                end else begin
                    if (r == R_FINAL) begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                        r        <= '0;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
            end
        end
    end

    // Output register: capture the masked column for rows inside the output
    // window; otherwise keep the previous column and drop valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_col    <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= step && row_emits;
            frame_done <= step && row_emits && last_col && (r == R_FINAL);
            if (step && row_emits) begin
                out_col <= col_next;
                out_x   <= x;
                out_y   <= Y_W'(int'(r) - FIRST_OUT_ROW);
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_kxk.sv
// Bench for line_buffer_kxk: three instances (4x3 PAD=1, 4x3 PAD=0, 28x28
// defaults), a cycle table for the small padded case, hand sequences for
// reset and PAD=0, and a frame-level reference model for random streams.
module tb_line_buffer_kxk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0]  s_in_data, z_in_data, d_in_data;
    logic        s_in_valid, z_in_valid, d_in_valid;
    logic        s_in_ready, z_in_ready, d_in_ready;
    logic [23:0] s_out_col, z_out_col, d_out_col;
    logic        s_out_valid, z_out_valid, d_out_valid;
    logic [1:0]  s_out_x, z_out_x;
    logic [4:0]  d_out_x;
    logic [1:0]  s_out_y;
    logic [0:0]  z_out_y;
    logic [4:0]  d_out_y;
    logic        s_frame_done, z_frame_done, d_frame_done;

    line_buffer_kxk #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .K(3), .PAD(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_col(s_out_col), .out_valid(s_out_valid),
        .out_x(s_out_x), .out_y(s_out_y), .frame_done(s_frame_done));

    line_buffer_kxk #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .K(3), .PAD(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_data(z_in_data), .in_valid(z_in_valid),
        .in_ready(z_in_ready), .out_col(z_out_col), .out_valid(z_out_valid),
        .out_x(z_out_x), .out_y(z_out_y), .frame_done(z_frame_done));

    line_buffer_kxk #(.DATA_W(8), .IMG_W(28), .IMG_H(28), .K(3), .PAD(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .out_col(d_out_col), .out_valid(d_out_valid),
        .out_x(d_out_x), .out_y(d_out_y), .frame_done(d_frame_done));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] col;
        int          x;
        int          y;
        bit          done;
    } exp_t;

    typedef struct {
        bit          vld;
        logic [7:0]  data;
        bit          exp_rdy;
        bit          exp_ov;
        logic [23:0] exp_col;
        int          exp_x;
        int          exp_y;
        bit          exp_done;
    } vec_t;

    exp_t q_s[$];
    exp_t q_d[$];
    int   pix [28][28];
    bit   mon_s = 1'b0;
    bit   mon_d = 1'b0;
    int   s_vcnt, s_dcnt, d_vcnt, d_dcnt;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [23:0] mk(input int l0, input int l1, input int l2);
        return {8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic vec_t v(input bit vld, input int d, input bit rdy, input bit ov,
                               input int l0, input int l1, input int l2,
                               input int x, input int y, input bit done);
        vec_t t;
        t.vld = vld; t.data = 8'(d); t.exp_rdy = rdy; t.exp_ov = ov;
        t.exp_col = mk(l0, l1, l2); t.exp_x = x; t.exp_y = y; t.exp_done = done;
        return t;
    endfunction

    task automatic set_in(input int which, input bit vl, input logic [7:0] d);
        case (which)
            0: begin s_in_valid = vl; s_in_data = d; end
            1: begin z_in_valid = vl; z_in_data = d; end
            default: begin d_in_valid = vl; d_in_data = d; end
        endcase
    endtask

    function automatic bit get_ready(input int which);
        case (which)
            0: return s_in_ready;
            1: return z_in_ready;
            default: return d_in_ready;
        endcase
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? q_s.size() : q_d.size();
    endfunction

    // Expected columns of a whole frame, enumerated in output coordinates:
    // output row oy, lane j looks at image row oy-P+j, zero outside the image.
    task automatic model_frame(input int which, input int w, input int h,
                               input int kk, input int p, input int base);
        int oh;
        exp_t e;
        oh = h + 2 * p - kk + 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int xx = 0; xx < w; xx++) begin
                e.col = '0;
                for (int j = 0; j < kk; j++) begin
                    int src;
                    src = oy - p + j;
                    if (src >= 0 && src < h) e.col[j*8 +: 8] = 8'(pix[src][xx] + base);
                end
                e.x = xx;
                e.y = oy;
                e.done = (oy == oh - 1) && (xx == w - 1);
                if (which == 0) q_s.push_back(e);
                else q_d.push_back(e);
            end
        end
    endtask

    task automatic drive_frame(input int which, input int w, input int h,
                               input int base, input int gap_pct);
        bit rdy;
        bit accepted;
        int waited;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                    @(negedge clk);
                    set_in(which, 1'b0, 8'h00);
                    @(posedge clk);
                end
                accepted = 1'b0;
                waited = 0;
                while (!accepted) begin
                    @(negedge clk);
                    set_in(which, 1'b1, 8'(pix[yy][xx] + base));
                    rdy = get_ready(which);
                    @(posedge clk);
                    accepted = rdy;
                    waited++;
                    if (waited > 100) begin
                        fail_msg($sformatf("ready_timeout dut%0d pixel(%0d,%0d)", which, xx, yy));
                        return;
                    end
                end
            end
        end
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 300; i++) begin
            if (qsize(which) == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk($sformatf("dut%0d_pending_columns", which), qsize(which), 0);
    endtask

    // Scoreboard monitor for the small padded instance.
    always @(negedge clk) begin
        if (mon_s && s_frame_done) s_dcnt++;
        if (mon_s && s_out_valid) begin
            exp_t e;
            s_vcnt++;
            if (q_s.size() == 0) begin
                fail_msg("s_unexpected_column");
            end else begin
                e = q_s.pop_front();
                chk($sformatf("s_col y%0d x%0d", e.y, e.x), s_out_col, e.col);
                chk("s_x", s_out_x, e.x);
                chk("s_y", s_out_y, e.y);
                chk("s_done", s_frame_done, e.done);
            end
        end else if (mon_s && s_frame_done) begin
            fail_msg("s_done_without_valid");
        end
    end

    // Scoreboard monitor for the default-size instance.
    always @(negedge clk) begin
        if (mon_d && d_frame_done) d_dcnt++;
        if (mon_d && d_out_valid) begin
            exp_t e;
            d_vcnt++;
            if (q_d.size() == 0) begin
                fail_msg("d_unexpected_column");
            end else begin
                e = q_d.pop_front();
                chk($sformatf("d_col y%0d x%0d", e.y, e.x), d_out_col, e.col);
                chk("d_x", d_out_x, e.x);
                chk("d_y", d_out_y, e.y);
                chk("d_done", d_frame_done, e.done);
            end
        end else if (mon_d && d_frame_done) begin
            fail_msg("d_done_without_valid");
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int zc;

        // 4x3, K=3, PAD=1, pixel = 10*y+x; one record per clock.
        tbl[0]  = v(1,  0, 1, 0,  0,  0,  0, 0, 0, 0);
        tbl[1]  = v(1,  1, 1, 0,  0,  0,  0, 0, 0, 0);
        tbl[2]  = v(1,  2, 1, 0,  0,  0,  0, 0, 0, 0);
        tbl[3]  = v(1,  3, 1, 0,  0,  0,  0, 0, 0, 0);
        tbl[4]  = v(1, 10, 1, 1,  0,  0, 10, 0, 0, 0);
        tbl[5]  = v(1, 11, 1, 1,  0,  1, 11, 1, 0, 0);
        tbl[6]  = v(1, 12, 1, 1,  0,  2, 12, 2, 0, 0);
        tbl[7]  = v(1, 13, 1, 1,  0,  3, 13, 3, 0, 0);
        tbl[8]  = v(1, 20, 1, 1,  0, 10, 20, 0, 1, 0);
        tbl[9]  = v(1, 21, 1, 1,  1, 11, 21, 1, 1, 0);
        tbl[10] = v(1, 22, 1, 1,  2, 12, 22, 2, 1, 0);
        tbl[11] = v(1, 23, 1, 1,  3, 13, 23, 3, 1, 0);
        tbl[12] = v(1, 99, 0, 1, 10, 20,  0, 0, 2, 0);
        tbl[13] = v(1, 99, 0, 1, 11, 21,  0, 1, 2, 0);
        tbl[14] = v(1, 99, 0, 1, 12, 22,  0, 2, 2, 0);
        tbl[15] = v(1, 99, 0, 1, 13, 23,  0, 3, 2, 1);
        tbl[16] = v(0,  0, 1, 0,  0,  0,  0, 0, 0, 0);

        rst_n = 1'b0;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s_valid", s_out_valid, 0);
        chk("reset_s_col", s_out_col, 0);
        chk("reset_s_ready", s_in_ready, 1);
        chk("reset_s_x", s_out_x, 0);
        chk("reset_s_y", s_out_y, 0);
        chk("reset_s_done", s_frame_done, 0);
        chk("reset_z_valid", z_out_valid, 0);
        chk("reset_z_ready", z_in_ready, 1);
        chk("reset_d_valid", d_out_valid, 0);
        chk("reset_d_ready", d_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, first output and flush on the small padded instance.
        vcnt = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            set_in(0, tbl[k].vld, tbl[k].data);
            chk($sformatf("tbl%0d_ready", k), s_in_ready, tbl[k].exp_rdy);
            @(posedge clk);
            #1;
            if (s_out_valid) vcnt++;
            chk($sformatf("tbl%0d_valid", k), s_out_valid, tbl[k].exp_ov);
            chk($sformatf("tbl%0d_done", k), s_frame_done, tbl[k].exp_done);
            if (tbl[k].exp_ov) begin
                chk($sformatf("tbl%0d_col", k), s_out_col, tbl[k].exp_col);
                chk($sformatf("tbl%0d_x", k), s_out_x, tbl[k].exp_x);
                chk($sformatf("tbl%0d_y", k), s_out_y, tbl[k].exp_y);
            end
        end
        chk("tbl_valid_count", vcnt, 12);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00);

        // Back-to-back frames with in_valid held through FLUSH.
        for (int yy = 0; yy < 28; yy++)
            for (int xx = 0; xx < 28; xx++)
                pix[yy][xx] = int'($urandom_range(1, 99));
        model_frame(0, 4, 3, 3, 1, 0);
        model_frame(0, 4, 3, 3, 1, 100);
        s_vcnt = 0;
        s_dcnt = 0;
        mon_s = 1'b1;
        drive_frame(0, 4, 3, 0, 0);
        drive_frame(0, 4, 3, 100, 0);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00);
        drain(0);
        mon_s = 1'b0;
        chk("b2b_valid_count", s_vcnt, 24);
        chk("b2b_done_count", s_dcnt, 2);

        // PAD=0: only the last row emits, no stall.
        zc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(1, 1'b1, 8'(10 * (i / 4) + i % 4));
            chk($sformatf("z_ready%0d", i), z_in_ready, 1);
            @(posedge clk);
            #1;
            if (z_out_valid) zc++;
            chk($sformatf("z_valid%0d", i), z_out_valid, (i / 4) == 2);
            chk($sformatf("z_done%0d", i), z_frame_done, i == 11);
            if ((i / 4) == 2) begin
                chk($sformatf("z_col%0d", i), z_out_col, mk(i % 4, 10 + i % 4, 20 + i % 4));
                chk($sformatf("z_x%0d", i), z_out_x, i % 4);
                chk($sformatf("z_y%0d", i), z_out_y, 0);
            end
        end
        @(negedge clk);
        set_in(1, 1'b0, 8'h00);
        chk("z_ready_after_frame", z_in_ready, 1);
        chk("z_valid_count", zc, 4);

        // Reset in the middle of a default-size frame.
        for (int yy = 0; yy < 28; yy++)
            for (int xx = 0; xx < 28; xx++)
                pix[yy][xx] = int'($urandom_range(0, 255));
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            set_in(2, 1'b1, 8'(pix[i / 28][i % 28]));
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_valid", d_out_valid, 0);
            chk("midrst_col", d_out_col, 0);
            chk("midrst_x", d_out_x, 0);
            chk("midrst_y", d_out_y, 0);
            chk("midrst_done", d_frame_done, 0);
            chk("midrst_ready", d_in_ready, 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(2, 1'b0, 8'h00);
        chk("release_ready", d_in_ready, 1);
        chk("release_valid", d_out_valid, 0);
        @(posedge clk);
        #1;
        chk("idle_valid", d_out_valid, 0);

        // Default frame with random bubbles, then the same frame gap-free.
        model_frame(2, 28, 28, 3, 1, 0);
        d_vcnt = 0;
        d_dcnt = 0;
        mon_d = 1'b1;
        drive_frame(2, 28, 28, 0, 30);
        @(negedge clk);
        set_in(2, 1'b0, 8'h00);
        drain(2);
        chk("bubble_valid_count", d_vcnt, 784);
        chk("bubble_done_count", d_dcnt, 1);

        model_frame(2, 28, 28, 3, 1, 0);
        d_vcnt = 0;
        d_dcnt = 0;
        drive_frame(2, 28, 28, 0, 0);
        @(negedge clk);
        set_in(2, 1'b0, 8'h00);
        drain(2);
        mon_d = 1'b0;
        chk("gapfree_valid_count", d_vcnt, 784);
        chk("gapfree_done_count", d_dcnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_kxk.md
Name: line_buffer_kxk

Overview:
- Parametrised successor to the fixed 3-row, 8-bit line buffer. Takes a raster pixel stream and emits one K-tall vertical column per accepted pixel.
- Configurable data width, kernel height, image size and vertical zero padding.
- Generates top padding internally and flushes bottom-padding rows at end of frame, under a ready/valid input handshake.
- Sits between the pixel source and the window generator. Horizontal padding remains the window generator's job.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 28: pixels per row.
- IMG_H, 28: rows per frame.
- K, 3: kernel height. Odd, ≥3.
- PAD, 1: vertical zero-pad rows above and below the image. Range 0..K/2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- in_data  in  DATA_W  pixel, raster order.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_col  out  K*DATA_W  column. Lane j = bits [j*DATA_W +: DATA_W]. Lane 0 is the top (oldest) row, lane K-1 the bottom.
- out_valid  out  1  out_col/out_x/out_y valid this cycle.
- out_x  out  $clog2(IMG_W)  column index of out_col.
- out_y  out  $clog2(OUT_H)  output row index, where OUT_H = IMG_H+2*PAD-K+1.
- frame_done  out  1  one-cycle pulse coincident with the last valid column of a frame.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_col=0, out_valid=0, out_x=0, out_y=0, frame_done=0, in_ready=1.
  - Column/row counters cleared, state RUN.
  - Line memories are not cleared; correctness must not depend on their contents.
- Storage: K-1 line memories of IMG_W x DATA_W, shifted per column exactly as a K-row delay line.
- Accept = in_valid && in_ready.
- Each accepted pixel at (x, r) produces a registered output next cycle (latency 1). Lane j carries the pixel at row r-(K-1)+j.
- Lanes whose source row is <0 or ≥IMG_H are forced to zero by mux. No memory clearing is used for this.
- out_valid=1 only when r ≥ K-1-PAD. Then out_y = r-(K-1)+PAD and out_x = x.
- Earlier rows fill the memories silently: out_valid=0 and out_col holds its last value.
- No accept in a cycle: out_valid=0, all registers hold.
- FSM:
  - RUN: in_ready=1; x wraps at IMG_W-1, r increments.
  - RUN → FLUSH when the pixel (IMG_W-1, IMG_H-1) is accepted and PAD>0.
  - FLUSH: in_ready=0; in_valid ignored and upstream holds its data. Runs PAD*IMG_W cycles at virtual rows r = IMG_H..IMG_H+PAD-1, one column per cycle, out_valid=1.
  - FLUSH → RUN after the last flush column; x, r cleared.
  - PAD=0: no FLUSH; counters clear on the last input pixel.
- frame_done accompanies out_x=IMG_W-1, out_y=OUT_H-1.
- Valid columns per frame = OUT_H*IMG_W (784 for the defaults).
- Back-to-back frames: the first accept of frame N+1 may occur on the cycle after FLUSH ends. Frame N data must never appear in frame N+1 output; the zero-lane rule guarantees this.
- Reset mid-frame abandons the frame; no frame_done is produced for it.

Decomposition:
- Shared package (cnn_pkg): DATA_W default, lane-index helper function, OUT_H computation function, FSM state enum {RUN, FLUSH}.
- Sub-module: line_mem (single IMG_W x DATA_W row memory with read-before-write at a shared column address), instantiated K-1 times.
- Row/column counters, FSM and zero-lane mux stay in the top module.

Test Plan:
- Reset: hold rst_n low 3 cycles mid-stream -> all outputs 0, in_ready=1 on the first cycle after release.
- Fill and first output, IMG_W=4, IMG_H=3, K=3, PAD=1, pixel=10*y+x:
  - No out_valid during row 0.
  - Pixel 12 at (2,1) -> next cycle out_col lanes {0,2,12}, out_x=2, out_y=0.
- Flush, same config: after pixel 23 is accepted, in_ready=0 for 4 cycles.
  - Columns {10,20,0}, {11,21,0}, {12,22,0}, {13,23,0} at out_y=2.
  - frame_done with {13,23,0}; total out_valid count = 12.
- Bubbles: random in_valid gaps over the default 28x28 frame -> exactly 784 valid columns, identical to the gap-free run.
- Back-to-back frames: in_valid held high through FLUSH; frame 2 pixels = 100+frame 1 values -> no frame 1 value appears in frame 2 lanes, and lane 0 is 0 at out_y=0.
- PAD=0 variant, K=3, 4x3 -> first valid on pixel (0,2) = {0,10,20}, 4 valid columns, no in_ready drop, frame_done on pixel 23's output.
